naneye_frame_tx: RTL and testbench
==================================

// Module: naneye_frame_tx
// PURPOSE
//  Sensor-side frame transmitter: the emitting end of the serial link decoded by RX_DECODER/RX_DESERIALIZER.
//  Takes 10-bit pixels over a ready/valid handshake, frames each as a 12-bit word, Manchester-encodes
//  it, and inserts frame/line sync runs. Drives a single-ended serial line.
//  Use: stimulus source for the receive chain and loopback self-test in the sensor-interface FPGA.
// PARAMETERS
//  C_ROWS           320  rows per frame
//  C_COLUMNS        320  pixels per row
//  HALF_BIT_CYCLES  4    CLOCK cycles per Manchester half-bit (>=2)
//  FSYNC_HALFBITS   64   frame-sync length, half-bits, level 1 (>=4)
//  LSYNC_HALFBITS   16   line-sync length, half-bits, level 0 (>=4)
// PORTS
//  CLOCK        in   1   bit-rate source clock
//  RESET        in   1   async reset, active high
//  ENABLE       in   1   transmitter enable
//  START        in   1   1-cycle frame request
//  PIX_DATA     in   10  pixel value
//  PIX_VALID    in   1   PIX_DATA valid
//  PIX_READY    out  1   1-cycle pulse: pixel slot opening, PIX_DATA sampled this cycle
//  TX_OUT       out  1   serial line (registered)
//  TX_OE        out  1   line driver enable
//  FRAME_BUSY   out  1   high from START accept to frame end
//  LINE_END     out  1   1-cycle pulse after last stop half-bit of each row
//  FRAME_END    out  1   1-cycle pulse on normal frame completion
//  UNDERRUN     out  1   1-cycle pulse when PIX_READY seen without PIX_VALID
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0. Reset mid-frame aborts immediately, no FRAME_END.
//  Half-bit tick: down-counter reloaded with HALF_BIT_CYCLES-1; counts only when state != IDLE.
//  Word: {start=1, D[9:0] MSB first, stop=0} = 12 bits = 24 half-bits.
//  Manchester: bit 1 -> half-bits 1,0; bit 0 -> 0,1. Max 2 equal half-bits in data; sync runs unambiguous.
//  FSM IDLE->FSYNC->LSYNC->PIXEL->(LSYNC|TAIL)->IDLE:
//   IDLE : TX_OUT=0, TX_OE=0. START&ENABLE -> FSYNC next cycle; TX_OE=1, FRAME_BUSY=1 same edge.
//   FSYNC: TX_OUT=1 for FSYNC_HALFBITS half-bits -> LSYNC.
//   LSYNC: TX_OUT=0 for LSYNC_HALFBITS half-bits -> PIXEL, col=0.
//   PIXEL: on first cycle of each word PIX_READY=1; load PIX_DATA if PIX_VALID, else load 10'h000
//          and pulse UNDERRUN same cycle. Word timing never stretches.
//          After 24th half-bit: col<C_COLUMNS-1 -> next word, col++; else LINE_END pulse, row++,
//          row<C_ROWS-1 -> LSYNC, else TAIL.
//   TAIL : one LSYNC_HALFBITS run of 0, then FRAME_END pulse, FRAME_BUSY=0, TX_OE=0 -> IDLE.
//  START while FRAME_BUSY: ignored. START with ENABLE=0: ignored.
//  ENABLE low mid-frame: at next half-bit tick -> IDLE, TX_OUT=0, TX_OE=0, FRAME_BUSY=0, no FRAME_END.
//  START and ENABLE-fall same cycle in IDLE: stays IDLE.
//  Latency: START accept -> TX_OUT=1 on next CLOCK edge. PIX_READY -> first start half-bit on TX_OUT: 1 cycle.
//  Frame length, half-bits: FSYNC + C_ROWS*(LSYNC + 24*C_COLUMNS) + LSYNC, each HALF_BIT_CYCLES clocks.
//  Counters: col $clog2(C_COLUMNS), row $clog2(C_ROWS), half-bit index 5 bits, sync run $clog2(max sync)+1.
// STRUCTURE
//  Package naneye_tx_pkg: state enum (IDLE,FSYNC,LSYNC,PIXEL,TAIL), C_WORD_BITS=12, C_START_BIT=1,
//   C_STOP_BIT=0, Manchester encode function.
//  Sub-module naneye_manchester_ser: 12-bit shift register + half-bit phase, load/tick in, half-bit out,
//   word_done pulse. Top holds FSM, tick divider, row/col counters, handshake.
// TESTING
//  Params C_ROWS=2, C_COLUMNS=3, HALF_BIT_CYCLES=2, FSYNC=8, LSYNC=4 unless noted.
//  1 Reset, START, PIX_VALID=1 always, data 0x3FF,0x000,0x2AA.. -> FRAME_END after (8+2*(4+72)+4)*2=328
//    cycles from START; 6 PIX_READY, 2 LINE_END, 0 UNDERRUN.
//  2 Pixel 0x2AA -> TX_OUT half-bits 10 10 01 10 01 10 01 10 01 10 01 01 (start, data MSB-first, stop).
//  3 Loopback via RX_DECODER/RX_DESERIALIZER (C_ROWS=C_COLUMNS=320, HALF_BIT_CYCLES=4 @400MHz):
//    PAR_OUTPUT[10:1] equals sent pixels, PIXEL_ERROR never set, 320 LINE_END.
//  4 PIX_VALID=0 for 2nd pixel -> UNDERRUN pulse on its PIX_READY cycle, 0x000 sent, timing unchanged.
//  5 ENABLE low mid-row -> TX_OE=0 within 2 cycles, no FRAME_END; new START restarts with FSYNC.
//  6 START while busy, and RESET mid-PIXEL -> START ignored; reset clears all outputs immediately.

Source files
------------

// File: rtl/naneye_tx_pkg.sv
// -----------------------------------------------------------------------------
// naneye_tx_pkg
//   Shared definitions for the NanEye frame transmitter: FSM state encoding,
//   word framing constants and the Manchester half-bit encoder.
//   No ports (package).
// -----------------------------------------------------------------------------
package naneye_tx_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FSYNC = 3'd1,
    LSYNC = 3'd2,
    PIXEL = 3'd3,
    TAIL  = 3'd4
  } tx_state_t;

  localparam int   C_PIX_BITS      = 10;
  localparam int   C_WORD_BITS     = 12;               // start + 10 data + stop
  localparam int   C_WORD_HALFBITS = 2 * C_WORD_BITS;  // 24 half-bits per word
  localparam int   C_HB_IDX_W      = 5;                // half-bit index 0..23
  localparam logic C_START_BIT     = 1'b1;
  localparam logic C_STOP_BIT      = 1'b0;

  // Manchester pair for one bit, returned as {first half, second half}:
  // 1 -> 1,0 and 0 -> 0,1.
  function automatic logic [1:0] manchester_enc(input logic bit_in);
    return bit_in ? 2'b10 : 2'b01;
  endfunction

  // Serial word for one pixel, transmitted MSB first.
  function automatic logic [C_WORD_BITS-1:0] frame_word(input logic [C_PIX_BITS-1:0] pix);
    return {C_START_BIT, pix, C_STOP_BIT};
  endfunction

endpackage

// File: rtl/naneye_manchester_ser.sv
// -----------------------------------------------------------------------------
// naneye_manchester_ser
//   Holds one 12-bit framed pixel word and walks through its 24 Manchester
//   half-bits, one per half-bit tick. The parent registers the line output,
//   so this block exposes the half-bit that follows the current one.
// Ports
//   i_clk        clock
//   i_rst        async reset, active high
//   i_load       load a new word (takes priority over i_tick)
//   i_data       10-bit pixel to frame on load
//   i_tick       advance to the next half-bit
//   o_next_half  value of the half-bit that follows the current one
//   o_last_half  current half-bit is the 24th (second half of the stop bit)
//   o_word_done  1-cycle pulse: tick on the last half-bit of the word
// -----------------------------------------------------------------------------
module naneye_manchester_ser
  import naneye_tx_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_load,
  input  logic [C_PIX_BITS-1:0] i_data,
  input  logic                  i_tick,
  output logic                  o_next_half,
  output logic                  o_last_half,
  output logic                  o_word_done
);

  logic [C_WORD_BITS-1:0] r_shreg;  // current bit sits in the MSB
  logic                   r_phase;  // 0: first half of the bit, 1: second half
  logic [C_HB_IDX_W-1:0]  r_idx;    // half-bit index within the word

  logic [1:0] w_cur_pair;
  logic [1:0] w_nxt_pair;

  assign w_cur_pair = manchester_enc(r_shreg[C_WORD_BITS-1]);
  assign w_nxt_pair = manchester_enc(r_shreg[C_WORD_BITS-2]);

  // In the first half the follow-on is this bit's second half; in the second
  // half it is the first half of the next bit down.
  assign o_next_half = r_phase ? w_nxt_pair[1] : w_cur_pair[0];
  assign o_last_half = (r_idx == C_HB_IDX_W'(C_WORD_HALFBITS - 1));
  assign o_word_done = i_tick & o_last_half;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values and they all update together.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shreg <= '0;
      r_phase <= 1'b0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_shreg <= frame_word(i_data);
      r_phase <= 1'b0;
      r_idx   <= '0;
    end else if (i_tick && !o_last_half) begin
      r_idx <= r_idx + C_HB_IDX_W'(1);
      if (r_phase) begin
        r_shreg <= {r_shreg[C_WORD_BITS-2:0], 1'b0};
        r_phase <= 1'b0;
      end else begin
        r_phase <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/naneye_frame_tx.sv
// -----------------------------------------------------------------------------
// naneye_frame_tx
//   Sensor-side frame transmitter. Frames 10-bit pixels as 12-bit words,
//   Manchester-encodes them and inserts a frame-sync run (level 1) before the
//   frame, a line-sync run (level 0) before every row and one trailing
//   line-sync-length run of 0 after the last row.
// Parameters
//   C_ROWS, C_COLUMNS   frame geometry
//   HALF_BIT_CYCLES     clocks per Manchester half-bit (>= 2)
//   FSYNC_HALFBITS      frame-sync run length in half-bits (>= 4)
//   LSYNC_HALFBITS      line-sync run length in half-bits (>= 4)
// Ports
//   i_clk          bit-rate source clock
//   i_rst          async reset, active high
//   i_enable       transmitter enable; low mid-frame aborts at next half-bit
//   i_start        1-cycle frame request (ignored while busy or disabled)
//   i_pix_data     pixel value, sampled in the o_pix_ready cycle
//   i_pix_valid    i_pix_data valid; if low at o_pix_ready a zero pixel is sent
//   o_pix_ready    1-cycle pulse, the cycle before a word starts on the line
//   o_tx_out       serial line (registered)
//   o_tx_oe        line driver enable
//   o_frame_busy   high from START accept to frame end / abort
//   o_line_end     1-cycle pulse after the last stop half-bit of each row
//   o_frame_end    1-cycle pulse on normal frame completion
//   o_underrun     pulse in an o_pix_ready cycle without i_pix_valid
// -----------------------------------------------------------------------------
module naneye_frame_tx
  import naneye_tx_pkg::*;
#(
  parameter int C_ROWS          = 320,
  parameter int C_COLUMNS       = 320,
  parameter int HALF_BIT_CYCLES = 4,
  parameter int FSYNC_HALFBITS  = 64,
  parameter int LSYNC_HALFBITS  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_enable,
  input  logic                  i_start,
  input  logic [C_PIX_BITS-1:0] i_pix_data,
  input  logic                  i_pix_valid,
  output logic                  o_pix_ready,
  output logic                  o_tx_out,
  output logic                  o_tx_oe,
  output logic                  o_frame_busy,
  output logic                  o_line_end,
  output logic                  o_frame_end,
  output logic                  o_underrun
);

  localparam int COL_W    = (C_COLUMNS > 1) ? $clog2(C_COLUMNS) : 1;
  localparam int ROW_W    = (C_ROWS > 1) ? $clog2(C_ROWS) : 1;
  localparam int SYNC_MAX = (FSYNC_HALFBITS > LSYNC_HALFBITS) ? FSYNC_HALFBITS : LSYNC_HALFBITS;
  localparam int SYNC_W   = $clog2(SYNC_MAX) + 1;
  localparam int DIV_W    = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;

  localparam logic [COL_W-1:0]  C_COL_LAST   = COL_W'(C_COLUMNS - 1);
  localparam logic [ROW_W-1:0]  C_ROW_LAST   = ROW_W'(C_ROWS - 1);
  localparam logic [SYNC_W-1:0] C_FSYNC_LAST = SYNC_W'(FSYNC_HALFBITS - 1);
  localparam logic [SYNC_W-1:0] C_LSYNC_LAST = SYNC_W'(LSYNC_HALFBITS - 1);
  localparam logic [DIV_W-1:0]  C_DIV_RELOAD = DIV_W'(HALF_BIT_CYCLES - 1);
  localparam logic [1:0]        C_START_PAIR = manchester_enc(C_START_BIT);

  tx_state_t          r_state;
  logic [DIV_W-1:0]   r_div;
  logic [SYNC_W-1:0]  r_sync;
  logic [COL_W-1:0]   r_col;
  logic [ROW_W-1:0]   r_row;
  logic               r_tx_out;
  logic               r_tx_oe;
  logic               r_busy;
  logic               r_pix_ready;
  logic               r_line_end;
  logic               r_frame_end;

  logic                  w_tick;
  logic                  w_pre_tick;
  logic                  w_word_next;
  logic                  w_load;
  logic                  w_ser_tick;
  logic [C_PIX_BITS-1:0] w_load_data;
  logic                  w_next_half;
  logic                  w_last_half;
  logic                  w_word_done;

  // Half-bit boundary: the last cycle of the current half-bit. The cycle
  // before it is used to announce the pixel slot one cycle ahead, which is
  // what lets the start half-bit appear on the line right after o_pix_ready.
  assign w_tick     = (r_state != IDLE) && (r_div == '0);
  assign w_pre_tick = (r_state != IDLE) && (r_div == DIV_W'(1));

  // The half-bit after the current one is the first half of a new word.
  assign w_word_next = ((r_state == LSYNC) && (r_sync == C_LSYNC_LAST)) ||
                       ((r_state == PIXEL) && w_last_half && (r_col != C_COL_LAST));

  assign w_load      = w_tick && i_enable && w_word_next;
  assign w_ser_tick  = w_tick && (r_state == PIXEL);
  // A missing pixel is replaced by zero so the word timing never stretches.
  assign w_load_data = i_pix_valid ? i_pix_data : '0;

  naneye_manchester_ser u_ser (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_load      (w_load),
    .i_data      (w_load_data),
    .i_tick      (w_ser_tick),
    .o_next_half (w_next_half),
    .o_last_half (w_last_half),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_div       <= '0;
      r_sync      <= '0;
      r_col       <= '0;
      r_row       <= '0;
      r_tx_out    <= 1'b0;
      r_tx_oe     <= 1'b0;
      r_busy      <= 1'b0;
      r_pix_ready <= 1'b0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      r_pix_ready <= w_pre_tick && w_word_next && i_enable;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;

      if ((r_state == IDLE) || (r_div == '0)) begin
        r_div <= C_DIV_RELOAD;
      end else begin
        r_div <= r_div - DIV_W'(1);
      end

      if (r_state == IDLE) begin
        if (i_start && i_enable) begin
          r_state  <= FSYNC;
          r_sync   <= '0;
          r_col    <= '0;
          r_row    <= '0;
          r_tx_out <= 1'b1;
          r_tx_oe  <= 1'b1;
          r_busy   <= 1'b1;
        end
      end else if (w_tick) begin
        if (!i_enable) begin
          // Abort at the half-bit boundary; no completion pulse.
          r_state  <= IDLE;
          r_tx_out <= 1'b0;
          r_tx_oe  <= 1'b0;
          r_busy   <= 1'b0;
        end else begin
          case (r_state)
            FSYNC: begin
              if (r_sync == C_FSYNC_LAST) begin
                r_state  <= LSYNC;
                r_sync   <= '0;
                r_tx_out <= 1'b0;
              end else begin
                r_sync <= r_sync + SYNC_W'(1);
              end
            end
            LSYNC: begin
              if (r_sync == C_LSYNC_LAST) begin
                r_state  <= PIXEL;
                r_col    <= '0;
                r_tx_out <= C_START_PAIR[1];
              end else begin
                r_sync <= r_sync + SYNC_W'(1);
              end
            end
            PIXEL: begin
              if (w_word_done) begin
                if (r_col != C_COL_LAST) begin
                  r_col    <= r_col + COL_W'(1);
                  r_tx_out <= C_START_PAIR[1];
                end else begin
                  r_line_end <= 1'b1;
                  r_col      <= '0;
                  r_sync     <= '0;
                  r_tx_out   <= 1'b0;
                  if (r_row != C_ROW_LAST) begin
                    r_row   <= r_row + ROW_W'(1);
                    r_state <= LSYNC;
                  end else begin
                    r_state <= TAIL;
                  end
                end
              end else begin
                r_tx_out <= w_next_half;
              end
            end
            TAIL: begin
              if (r_sync == C_LSYNC_LAST) begin
                r_state     <= IDLE;
                r_frame_end <= 1'b1;
                r_busy      <= 1'b0;
                r_tx_oe     <= 1'b0;
                r_tx_out    <= 1'b0;
              end else begin
                r_sync <= r_sync + SYNC_W'(1);
              end
            end
            default: begin
              r_state  <= IDLE;
              r_tx_out <= 1'b0;
              r_tx_oe  <= 1'b0;
              r_busy   <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign o_pix_ready  = r_pix_ready;
  assign o_tx_out     = r_tx_out;
  assign o_tx_oe      = r_tx_oe;
  assign o_frame_busy = r_busy;
  assign o_line_end   = r_line_end;
  assign o_frame_end  = r_frame_end;
  // Flagged in the slot cycle itself, when the missing valid is observed.
  assign o_underrun   = r_pix_ready & ~i_pix_valid;

endmodule

// File: tb/tb_naneye_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_naneye_frame_tx
//   Randomized frames against a reference model that builds the expected
//   serial stream from the framing rules (sync runs, start/data/stop words,
//   Manchester pairs) and places the handshake/status pulses at their
//   computed cycle offsets. A monitor compares every cycle of a frame.
// -----------------------------------------------------------------------------
module tb_naneye_frame_tx;

  localparam int ROWS = 2;
  localparam int COLS = 3;
  localparam int H    = 2;
  localparam int F    = 8;
  localparam int L    = 4;
  localparam int NPIX = ROWS * COLS;

  logic       clk;
  logic       i_rst;
  logic       i_enable;
  logic       i_start;
  logic [9:0] i_pix_data;
  logic       i_pix_valid;
  logic       o_pix_ready;
  logic       o_tx_out;
  logic       o_tx_oe;
  logic       o_frame_busy;
  logic       o_line_end;
  logic       o_frame_end;
  logic       o_underrun;

  naneye_frame_tx #(
    .C_ROWS          (ROWS),
    .C_COLUMNS       (COLS),
    .HALF_BIT_CYCLES (H),
    .FSYNC_HALFBITS  (F),
    .LSYNC_HALFBITS  (L)
  ) u_dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_enable     (i_enable),
    .i_start      (i_start),
    .i_pix_data   (i_pix_data),
    .i_pix_valid  (i_pix_valid),
    .o_pix_ready  (o_pix_ready),
    .o_tx_out     (o_tx_out),
    .o_tx_oe      (o_tx_oe),
    .o_frame_busy (o_frame_busy),
    .o_line_end   (o_line_end),
    .o_frame_end  (o_frame_end),
    .o_underrun   (o_underrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Expected per-cycle output vector:
  // {busy, oe, tx, pix_ready, line_end, frame_end, underrun}
  typedef struct {
    int         t;
    logic [6:0] sig;
  } exp_t;

  exp_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Frame content, written by the stimulus between frames.
  logic [9:0] fr_vals  [8];
  bit         fr_valid [8];

  // Monitor statistics for the frame in flight.
  int mon_ready;
  int mon_line;
  int mon_under;
  int mon_fe_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  // Reference model: expand the frame into half-bits, then into cycles.
  task automatic gen_frame(input int abort_t);
    bit         hb[$];
    logic [11:0] w;
    logic [6:0] v[];
    int         n, p, h0, last, tk;
    exp_t       e;
    for (int i = 0; i < F; i++) hb.push_back(1'b1);
    p = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int i = 0; i < L; i++) hb.push_back(1'b0);
      for (int c = 0; c < COLS; c++) begin
        w = {1'b1, (fr_valid[p] ? fr_vals[p] : 10'h000), 1'b0};
        for (int b = 11; b >= 0; b--) begin
          hb.push_back(w[b]);
          hb.push_back(!w[b]);
        end
        p++;
      end
    end
    for (int i = 0; i < L; i++) hb.push_back(1'b0);
    n = hb.size() * H;
    v = new[n + 1];
    for (int t = 0; t < n; t++) v[t] = {1'b1, 1'b1, hb[t / H], 4'b0000};
    v[n] = 7'b0000010;
    p = 0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        h0 = F + r * (L + 24 * COLS) + L + 24 * c;
        v[h0 * H - 1][3] = 1'b1;
        if (!fr_valid[p]) v[h0 * H - 1][0] = 1'b1;
        p++;
      end
      v[(F + (r + 1) * (L + 24 * COLS)) * H][2] = 1'b1;
    end
    last = n;
    if (abort_t >= 0) begin
      tk = abort_t;
      while ((tk % H) != (H - 1)) tk++;
      last = tk;
    end
    for (int t = 0; t <= last; t++) begin
      e.t   = t;
      e.sig = v[t];
      exp_q.push_back(e);
    end
    if (abort_t >= 0) begin
      for (int k = 1; k <= 2; k++) begin
        e.t   = last + k;
        e.sig = 7'b0;
        exp_q.push_back(e);
      end
    end
  endtask

  // Pixel source: presents fr_vals[idx] and advances on each accepted slot.
  initial begin
    int idx;
    idx         = 0;
    i_pix_data  = 10'h000;
    i_pix_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!o_frame_busy) idx = 0;
      i_pix_data  = fr_vals[idx];
      i_pix_valid = fr_valid[idx];
      if (o_pix_ready) begin
        @(posedge clk);
        #1;
        if (idx < 7) idx++;
        i_pix_data  = fr_vals[idx];
        i_pix_valid = fr_valid[idx];
      end
    end
  end

  // Monitor: one expected vector per cycle while a frame is in flight.
  initial begin
    exp_t       e;
    logic [6:0] act;
    mon_ready = 0;
    mon_line  = 0;
    mon_under = 0;
    mon_fe_t  = -1;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e.t == 0) begin
          mon_ready = 0;
          mon_line  = 0;
          mon_under = 0;
          mon_fe_t  = -1;
        end
        act = {o_frame_busy, o_tx_oe, o_tx_out, o_pix_ready,
               o_line_end, o_frame_end, o_underrun};
        if (act[3]) mon_ready++;
        if (act[2]) mon_line++;
        if (act[0]) mon_under++;
        if (act[1]) mon_fe_t = e.t;
        check($sformatf("cycle_t%0d", e.t), int'(act), int'(e.sig));
      end
    end
  end

  task automatic start_frame(input int abort_t);
    @(negedge clk);
    i_start = 1'b1;
    @(posedge clk);
    gen_frame(abort_t);
    #1 i_start = 1'b0;
  endtask

  // Waits for the monitor to consume the frame; optionally pokes START or
  // drops ENABLE at a given cycle offset from the frame start.
  task automatic wait_drain(input int poke_t, input int enable_off_t);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 3000) begin
      @(negedge clk);
      i_start = (n == poke_t);
      if (n == enable_off_t) i_enable = 1'b0;
      n++;
    end
    i_start = 1'b0;
    check("frame_drain_remaining", exp_q.size(), 0);
  endtask

  task automatic fill_random(input bit allow_invalid);
    for (int i = 0; i < 8; i++) begin
      fr_vals[i]  = 10'($urandom_range(0, 1023));
      fr_valid[i] = allow_invalid ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  endtask

  initial begin
    int exp_under;
    i_rst    = 1'b1;
    i_enable = 1'b1;
    i_start  = 1'b0;
    fill_random(1'b0);
    #3;
    check("reset_outputs", int'({o_frame_busy, o_tx_oe, o_tx_out, o_pix_ready,
                                 o_line_end, o_frame_end, o_underrun}), 0);
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", int'({o_frame_busy, o_tx_oe, o_tx_out}), 0);

    // Frame 1: boundary pixel values, all valid.
    fr_vals[0] = 10'h3FF;
    fr_vals[1] = 10'h000;
    fr_vals[2] = 10'h2AA;
    start_frame(-1);
    wait_drain(-1, -1);
    check("f1_pix_ready_count", mon_ready, 6);
    check("f1_line_end_count", mon_line, 2);
    check("f1_underrun_count", mon_under, 0);
    check("f1_frame_end_cycle", mon_fe_t, 328);

    // START with ENABLE low (ENABLE falling in the START cycle) is ignored.
    @(negedge clk);
    i_start  = 1'b1;
    i_enable = 1'b0;
    @(negedge clk);
    i_start  = 1'b0;
    i_enable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("start_disabled_idle%0d", i), int'({o_frame_busy, o_tx_oe}), 0);
      @(negedge clk);
    end

    // Frame 2: random data, second pixel missing, START poked while busy.
    fill_random(1'b1);
    fr_valid[1] = 1'b0;
    exp_under = 0;
    for (int i = 0; i < NPIX; i++) if (!fr_valid[i]) exp_under++;
    start_frame(-1);
    wait_drain(50, -1);
    check("f2_underrun_count", mon_under, exp_under);
    check("f2_frame_end_cycle", mon_fe_t, 328);

    // Frame 3: ENABLE dropped mid-row, abort without FRAME_END.
    fill_random(1'b0);
    start_frame(84);
    wait_drain(-1, 84);
    check("f3_no_frame_end", mon_fe_t, -1);
    @(negedge clk);
    i_enable = 1'b1;
    check("f3_idle_after_abort", int'({o_frame_busy, o_tx_oe, o_tx_out}), 0);

    // Frame 4: fresh START after the abort restarts with frame sync.
    fill_random(1'b1);
    start_frame(-1);
    wait_drain(-1, -1);
    check("f4_frame_end_cycle", mon_fe_t, 328);
    check("f4_line_end_count", mon_line, 2);

    // Frame 5: reset mid-PIXEL clears all outputs immediately.
    fill_random(1'b0);
    start_frame(-1);
    repeat (100) @(negedge clk);
    @(posedge clk);
    #1;
    exp_q.delete();
    i_rst = 1'b1;
    #1;
    check("midframe_reset_outputs", int'({o_frame_busy, o_tx_oe, o_tx_out, o_pix_ready,
                                          o_line_end, o_frame_end, o_underrun}), 0);
    repeat (2) @(negedge clk);
    i_rst = 1'b0;
    repeat (2) @(negedge clk);
    check("after_reset_idle", int'({o_frame_busy, o_tx_oe, o_frame_end}), 0);

    // Frame 6: normal operation resumes after reset.
    fill_random(1'b1);
    start_frame(-1);
    wait_drain(-1, -1);
    check("f6_frame_end_cycle", mon_fe_t, 328);
    check("f6_pix_ready_count", mon_ready, 6);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
